// File: rtl/plc_serializer.sv
// plc_serializer: takes a WIDTH-bit word over valid/ready, emits a one-cycle piso_start
// strobe and then the word LSB-first on o_ser_out. Optional holding buffer: PLC_SERIALIZER_HOLDBUF_EN.
module plc_serializer #(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_in_valid,
   input  logic [WIDTH-1:0] i_in_data,
   output logic             o_in_ready,
   output logic             o_piso_start,
   output logic             o_ser_out,
   output logic             o_busy,
   output logic             o_frame_done
);

   localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_SHIFT = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_shift;
   logic [WIDTH-1:0] w_shift_nxt;
   logic [CW-1:0]    r_cnt;
   logic [CW-1:0]    w_cnt_nxt;
   logic             w_accept;
   logic             w_last;
`ifdef PLC_SERIALIZER_HOLDBUF_EN
   logic [WIDTH-1:0] r_buf;
   logic [WIDTH-1:0] w_buf_nxt;
   logic             r_buf_full;
   logic             w_buf_full_nxt;
`endif

   assign w_last   = (r_state == ST_SHIFT) && (r_cnt == LAST_BIT);
   assign w_accept = i_in_valid && o_in_ready;

   // Output decode; every output depends on registered state only
   always_comb begin
      o_piso_start = (r_state == ST_START);
      o_busy       = (r_state != ST_IDLE);
      o_frame_done = w_last;
      o_ser_out    = 1'b0;
      if (r_state == ST_SHIFT) begin
         o_ser_out = r_shift[0];
      end else begin
         o_ser_out = 1'b0;
      end
`ifdef PLC_SERIALIZER_HOLDBUF_EN
      o_in_ready = (r_state == ST_IDLE) || !r_buf_full;
`else
      o_in_ready = (r_state == ST_IDLE);
`endif
   end

   // Next-state, shift register, bit counter and holding buffer
   always_comb begin
      w_state_nxt = r_state;
      w_shift_nxt = r_shift;
      w_cnt_nxt   = r_cnt;
`ifdef PLC_SERIALIZER_HOLDBUF_EN
      w_buf_nxt      = r_buf;
      w_buf_full_nxt = r_buf_full;
      // A word arriving mid-frame parks in the buffer; on the last bit it goes straight to START
      if (w_accept && (r_state != ST_IDLE) && !w_last) begin
         w_buf_nxt      = i_in_data;
         w_buf_full_nxt = 1'b1;
      end else begin
         w_buf_full_nxt = r_buf_full;
      end
`endif
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_state_nxt = ST_START;
               w_shift_nxt = i_in_data;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_START: begin
            w_state_nxt = ST_SHIFT;
            w_cnt_nxt   = {CW{1'b0}};
         end
         ST_SHIFT: begin
            w_shift_nxt = r_shift >> 1;
            if (w_last) begin
`ifdef PLC_SERIALIZER_HOLDBUF_EN
               if (r_buf_full) begin
                  w_state_nxt    = ST_START;
                  w_shift_nxt    = r_buf;
                  w_buf_full_nxt = 1'b0;
               end else if (w_accept) begin
                  w_state_nxt = ST_START;
                  w_shift_nxt = i_in_data;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
`else
               w_state_nxt = ST_IDLE;
`endif
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State, shift register and counter; reset aborts any frame in flight
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
         r_shift <= {WIDTH{1'b0}};
         r_cnt   <= {CW{1'b0}};
      end else begin
         r_state <= w_state_nxt;
         r_shift <= w_shift_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

`ifdef PLC_SERIALIZER_HOLDBUF_EN
   // Holding buffer register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_buf      <= {WIDTH{1'b0}};
         r_buf_full <= 1'b0;
      end else begin
         r_buf      <= w_buf_nxt;
         r_buf_full <= w_buf_full_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_plc_serializer.sv
// Directed bench for plc_serializer with an 8-bit deserializer model and a word scoreboard.
// Works in both builds (PLC_SERIALIZER_HOLDBUF_EN defined or not); a WIDTH=4 instance is also exercised.
module tb_plc_serializer;

`ifdef PLC_SERIALIZER_HOLDBUF_EN
   localparam bit HB = 1'b1;
`else
   localparam bit HB = 1'b0;
`endif
   localparam int PERIOD = HB ? 9 : 10;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready, piso_start, ser_out, busy, frame_done;
   logic       v4;
   logic [3:0] d4;
   logic       r4, p4, s4, b4, f4;

   always #5 clk = ~clk;

   plc_serializer #(.WIDTH(8)) dut (
      .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .i_in_data(in_data),
      .o_in_ready(in_ready), .o_piso_start(piso_start), .o_ser_out(ser_out),
      .o_busy(busy), .o_frame_done(frame_done)
   );

   plc_serializer #(.WIDTH(4)) dut4 (
      .i_clk(clk), .i_rst(rst), .i_in_valid(v4), .i_in_data(d4),
      .o_in_ready(r4), .o_piso_start(p4), .o_ser_out(s4),
      .o_busy(b4), .o_frame_done(f4)
   );

   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;

   task automatic chk_bit(input string tag, input logic obs, input logic exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // scoreboard: expected words pushed on each accepted handshake
   logic [7:0] exp_q[$];
   int         starts_q[$];
   int         cyc = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!rst && in_valid && in_ready) exp_q.push_back(in_data);
   end

   always @(negedge clk) begin
      if (piso_start) starts_q.push_back(cyc);
   end

   // deserializer model: no reset, ignores piso_start while shifting
   logic       rx_act   = 1'b0;
   int         rx_cnt   = 0;
   logic [7:0] rx_sh    = 8'h00;
   int         rx_words = 0;
   int         drop_idx = 0;

   always @(negedge clk) begin
      if (!rx_act) begin
         if (piso_start) begin
            rx_act <= 1'b1;
            rx_cnt <= 0;
         end
      end else begin
         rx_sh <= {ser_out, rx_sh[7:1]};
         if (rx_cnt == 7) begin
            rx_act   <= 1'b0;
            rx_words <= rx_words + 1;
            if (rx_words + 1 != drop_idx) begin
               if (exp_q.size() == 0) begin
                  chk_int("rx_unexpected_word", int'({ser_out, rx_sh[7:1]}), -1);
               end else begin
                  chk_int("rx_word", int'({ser_out, rx_sh[7:1]}), int'(exp_q.pop_front()));
               end
            end
         end else begin
            rx_cnt <= rx_cnt + 1;
         end
      end
   end

   // present a word and hold it until accepted; returns at the negedge after the accept edge
   task automatic send(input logic [7:0] w);
      int ok;
      ok       = 0;
      in_valid = 1'b1;
      in_data  = w;
      for (int k = 0; k < 40; k++) begin
         if (in_ready) begin
            ok = 1;
            break;
         end
         @(negedge clk);
      end
      chk_int("accept_within_budget", ok, 1);
      @(negedge clk);
   endtask

   initial begin
      logic [7:0] wa5;
      logic [3:0] w9;
      int         base, t0;
      wa5      = 8'hA5;
      w9       = 4'h9;
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      v4       = 1'b0;
      d4       = 4'h0;
      repeat (2) @(negedge clk);
      chk_bit("rst_in_ready", in_ready, 1'b1);
      chk_bit("rst_piso_start", piso_start, 1'b0);
      chk_bit("rst_ser_out", ser_out, 1'b0);
      chk_bit("rst_busy", busy, 1'b0);
      chk_bit("rst_frame_done", frame_done, 1'b0);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk_bit("idle_in_ready", in_ready, 1'b1);
         chk_bit("idle_piso_start", piso_start, 1'b0);
         chk_bit("idle_ser_out", ser_out, 1'b0);
         chk_bit("idle_busy", busy, 1'b0);
      end

      // single frame 0xA5, cycle by cycle
      base = rx_words;
      send(8'hA5);
      in_valid = 1'b0;
      chk_bit("a5_start_piso", piso_start, 1'b1);
      chk_bit("a5_start_ser", ser_out, 1'b0);
      chk_bit("a5_start_busy", busy, 1'b1);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk_bit("a5_bit", ser_out, wa5[i]);
         chk_bit("a5_piso_low", piso_start, 1'b0);
         chk_bit("a5_frame_done", frame_done, (i == 7));
      end
      @(negedge clk);
      chk_bit("a5_after_busy", busy, 1'b0);
      chk_bit("a5_after_ser", ser_out, 1'b0);
      chk_int("a5_rx_count", rx_words - base, 1);

      // back-to-back with in_valid held high
      repeat (3) @(negedge clk);
      starts_q.delete();
      base = rx_words;
      send(8'h3C);
      send(8'hC3);
      in_valid = 1'b0;
      repeat (25) @(negedge clk);
      chk_int("b2b_start_count", starts_q.size(), 2);
      if (starts_q.size() >= 2) chk_int("b2b_period", starts_q[1] - starts_q[0], PERIOD);
      chk_int("b2b_rx_count", rx_words - base, 2);
      chk_int("b2b_queue_empty", exp_q.size(), 0);

      // three words while busy: third is withheld until there is room
      base = rx_words;
      send(8'h11);
      chk_bit("three_ready_after_first", in_ready, HB);
      send(8'h22);
      chk_bit("three_ready_after_second", in_ready, 1'b0);
      t0 = cyc;
      send(8'h33);
      in_valid = 1'b0;
      chk_bit("three_third_withheld", (cyc - t0) > 5, 1'b1);
      repeat (40) @(negedge clk);
      chk_int("three_rx_count", rx_words - base, 3);
      chk_int("three_queue_empty", exp_q.size(), 0);

      // reset during bit 3 of 0xFF, then 0x81
      send(8'hFF);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk_bit("ff_bit3", ser_out, 1'b1);
      rst      = 1'b1;
      drop_idx = rx_words + 1;
      exp_q.delete();
      @(negedge clk);
      chk_bit("abort_ser_out", ser_out, 1'b0);
      chk_bit("abort_busy", busy, 1'b0);
      chk_bit("abort_in_ready", in_ready, 1'b1);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      base = rx_words;
      starts_q.delete();
      send(8'h81);
      in_valid = 1'b0;
      chk_bit("r81_fresh_start", piso_start, 1'b1);
      repeat (12) @(negedge clk);
      chk_int("r81_rx_count", rx_words - base, 1);
      chk_int("r81_start_count", starts_q.size(), 1);
      chk_int("r81_queue_empty", exp_q.size(), 0);

      // WIDTH=4 instance, word 0x9
      v4 = 1'b1;
      d4 = 4'h9;
      chk_bit("w4_ready", r4, 1'b1);
      @(negedge clk);
      v4 = 1'b0;
      chk_bit("w4_start_piso", p4, 1'b1);
      chk_bit("w4_start_ser", s4, 1'b0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk_bit("w4_bit", s4, w9[i]);
         chk_bit("w4_frame_done", f4, (i == 3));
         chk_bit("w4_busy", b4, 1'b1);
      end
      @(negedge clk);
      chk_bit("w4_end_busy", b4, 1'b0);
      chk_bit("w4_end_piso", p4, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, observed %0d checks, expected completion", n_total);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/plc_serializer.md
# plc_serializer

Parallel-in/serial-out transmitter for the PLC link. Accepts a WIDTH-bit word over a valid/ready handshake and emits a one-cycle `piso_start` strobe, then the word LSB-first on `ser_out`, one bit per clock. It is the transmit end of the link into the 8-bit PLC deserializer; with WIDTH=8 its framing matches that receiver cycle for cycle. An optional one-word holding buffer allows back-to-back frames with no idle cycle between them.

## Interface
- `WIDTH`, default 8: word width in bits; legal values ≥ 2. Must be 8 when driving the PLC deserializer.
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `in_data` holds a word to send.
- `in_data`  in  WIDTH  word to serialize; sampled only on an accept edge.
- `in_ready`  out  1  block can accept a word this cycle.
- `piso_start`  out  1  frame-start strobe; high for exactly one cycle per frame.
- `ser_out`  out  1  serial data, LSB first.
- `busy`  out  1  a frame is in progress (state START or SHIFT).
- `frame_done`  out  1  high during the cycle that drives the last bit (bit WIDTH-1).

## Operation
- Accept: `in_valid && in_ready` at a rising edge. `in_data` is captured at that edge. `in_valid` without `in_ready` has no effect and the word is not consumed.
- States and transitions:
  - IDLE: if accept, load shift register and go to START; otherwise stay in IDLE.
  - START: `piso_start`=1, `ser_out`=0; always go to SHIFT with bit counter=0.
  - SHIFT: `ser_out`=shift[0]; shift right each cycle; counter increments.
  - When counter=WIDTH-1: assert `frame_done`. Next state is START if a word is pending (see Configuration), else IDLE.
- Outputs are registered or decoded from registered state only; there is no combinational path from `in_valid` to any output.
- The counter is `$clog2(WIDTH)` bits wide and resets to 0 on every entry to SHIFT. No wrap is ever used: the counter terminates at WIDTH-1.
- In IDLE: `ser_out`=0, `piso_start`=0, `frame_done`=0.
- `rst` behaviour:
  - Forces IDLE and clears the shift register, counter and holding buffer.
  - Reset values: `in_ready`=1, `piso_start`=0, `ser_out`=0, `busy`=0, `frame_done`=0.
  - Reset mid-frame aborts the frame immediately; the remaining bits are never driven. The receiver has no reset and will complete a corrupt word; the system controller discards it.
- `rst` and accept on the same edge: reset wins and the word is dropped.

## Timing
- Accept at edge E0 (from IDLE):
  - `piso_start`=1 in cycle E0→E1.
  - Bit i is on `ser_out` in cycle E(i+1)→E(i+2), for i = 0..WIDTH-1.
  - `frame_done` is high in cycle EW→E(W+1).
- The receiver samples `piso_start` at E1 and bits at E2..E(W+1).
- Frame length: 1 + WIDTH cycles (9 for WIDTH=8).
- The next `piso_start` may be driven in the cycle immediately after the last bit. The receiver ignores `piso_start` while it is shifting, so no earlier strobe is ever issued.

## Configuration
- Macro `PLC_SERIALIZER_HOLDBUF_EN`.
- Defined: a one-word holding buffer is compiled in.
  - `in_ready` = (state==IDLE) || !buf_full.
  - An accept during START or SHIFT loads the buffer.
  - At the last SHIFT cycle with buf_full: move the buffer into the shift register, clear buf_full, and go directly to START. Frame period is 9 cycles (WIDTH=8).
  - `in_ready` is 0 in that transfer cycle.
- Undefined: no buffer. `in_ready` = (state==IDLE). Back-to-back period is 10 cycles: one IDLE cycle, then START, then 8 bits.

## Test plan
- Reset then idle for 5 cycles: `in_ready`=1, `piso_start`=0, `ser_out`=0, `busy`=0 throughout.
- Send 0xA5 with a deserializer model attached:
  - `piso_start` is high for 1 cycle.
  - `ser_out` sequence is 1,0,1,0,0,1,0,1.
  - `frame_done` is high on the 8th bit.
  - Receiver `prl_out`=0xA5 after 9 cycles.
- Hold `in_valid`=1 with 0x3C then 0xC3:
  - With HOLDBUF_EN: `piso_start` pulses are 9 cycles apart.
  - Without HOLDBUF_EN: pulses are 10 cycles apart.
  - In both builds the receiver sees 0x3C then 0xC3.
- Holdbuf build, three words sent while busy: the third accept is withheld (`in_ready`=0) until the buffer drains; no word is lost or duplicated.
- Assert `rst` during bit 3 of 0xFF:
  - `ser_out`=0 and `busy`=0 on the next cycle.
  - A following 0x81 is transmitted correctly starting from a fresh `piso_start`.
- WIDTH=4, send 0x9: `ser_out` sequence is 1,0,0,1 and the frame is 5 cycles long.
